// File: rtl/reg_dump_unit_pkg.sv
// Shared processor definitions used by the register dump engine: register-index
// width, register count and the dump FSM state encoding.
package reg_dump_unit_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4
  } dump_state_t;

endpackage

// File: rtl/reg_dump_unit_if.sv
// Register-file read port plus the valid/ready dump word stream.
interface reg_dump_unit_if #(
  parameter int N = 32
);
  import reg_dump_unit_pkg::*;

  reg_idx_t       rf_raddr;
  logic [N-1:0]   rf_rdata;
  logic           dout_valid;
  logic           dout_ready;
  logic [N-1:0]   dout_data;
  reg_idx_t       dout_idx;
  logic           dout_last;

  modport master (
    output rf_raddr,
    output dout_valid,
    output dout_data,
    output dout_idx,
    output dout_last,
    input  rf_rdata,
    input  dout_ready
  );

  modport slave (
    input  rf_raddr,
    input  dout_valid,
    input  dout_data,
    input  dout_idx,
    input  dout_last,
    output rf_rdata,
    output dout_ready
  );

endinterface

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: freezes the core, walks FIRST..LAST through the
// combinational read port and streams each register out on a valid/ready port.
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int N     = 32,
  parameter int FIRST = 0,
  parameter int LAST  = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            stall,
  output logic            busy,
  output logic            done,
  reg_dump_unit_if.master bus
);

  localparam reg_idx_t FIRST_IDX = reg_idx_t'(FIRST);
  localparam reg_idx_t LAST_IDX  = reg_idx_t'(LAST);

  dump_state_t   state_r;
  dump_state_t   state_s;
  reg_idx_t      idx_r;
  reg_idx_t      idx_s;
  logic          valid_r;
  logic [N-1:0]  data_r;
  reg_idx_t      didx_r;
  logic          last_r;
  logic          stall_r;
  logic          busy_r;
  logic          done_r;

  assign bus.rf_raddr   = idx_r;
  assign bus.dout_valid = valid_r;
  assign bus.dout_data  = data_r;
  assign bus.dout_idx   = didx_r;
  assign bus.dout_last  = last_r;
  assign stall          = stall_r;
  assign busy           = busy_r;
  assign done           = done_r;

  // FSM state and index counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      idx_r   <= FIRST_IDX;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state and index-counter logic
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SETTLE;
          idx_s   = FIRST_IDX;
        end else begin
          state_s = ST_IDLE;
        end
      end
      // One cycle lets a negedge register write already in flight land first
      ST_SETTLE: state_s = ST_LOAD;
      ST_LOAD:   state_s = ST_SEND;
      ST_SEND: begin
        if (bus.dout_ready) begin
          if (idx_r < LAST_IDX) begin
            idx_s   = idx_r + 5'd1;
            state_s = ST_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        idx_s   = FIRST_IDX;
      end
    endcase
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      stall_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      valid_r <= (state_s == ST_SEND);
      last_r  <= (state_s == ST_SEND) && (idx_r == LAST_IDX);
      stall_r <= (state_s != ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Word capture; held untouched outside LOAD so SEND back-pressure is stable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= {N{1'b0}};
      didx_r <= 5'd0;
    end else if (state_r == ST_LOAD) begin
      data_r <= bus.rf_rdata;
      didx_r <= idx_r;
    end else begin
      data_r <= data_r;
      didx_r <= didx_r;
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Randomised self-checking bench for reg_dump_unit: full, partial and single-word
// dumps against a queue-based model of the expected word stream.
module tb_reg_dump_unit;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic stall0, stall1, stall2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic [31:0] rf [32];
  int errors = 0;
  int checks = 0;

  reg_dump_unit_if #(.N(32)) if0 ();
  reg_dump_unit_if #(.N(32)) if1 ();
  reg_dump_unit_if #(.N(32)) if2 ();

  assign if0.rf_rdata = rf[if0.rf_raddr];
  assign if1.rf_rdata = rf[if1.rf_raddr];
  assign if2.rf_rdata = rf[if2.rf_raddr];

  reg_dump_unit #(.N(32), .FIRST(0), .LAST(31)) u_full (
    .clk(clk), .rst(rst), .start(start0), .stall(stall0), .busy(busy0), .done(done0), .bus(if0));
  reg_dump_unit #(.N(32), .FIRST(1), .LAST(3)) u_part (
    .clk(clk), .rst(rst), .start(start1), .stall(stall1), .busy(busy1), .done(done1), .bus(if1));
  reg_dump_unit #(.N(32), .FIRST(5), .LAST(5)) u_one (
    .clk(clk), .rst(rst), .start(start2), .stall(stall2), .busy(busy2), .done(done2), .bus(if2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (if0.dout_valid !== 1'b0 || stall0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        if0.dout_last !== 1'b0 || if0.dout_data !== 32'd0 || if0.dout_idx !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b s=%b b=%b d=%b l=%b data=%h idx=%0d want all zero",
               if0.dout_valid, stall0, busy0, done0, if0.dout_last, if0.dout_data, if0.dout_idx);
    end
    checks++;
    if (if0.rf_raddr !== 5'd0 || if1.rf_raddr !== 5'd1 || if2.rf_raddr !== 5'd5) begin
      errors++;
      $display("FAIL reset_index got %0d/%0d/%0d want 0/1/5", if0.rf_raddr, if1.rf_raddr, if2.rf_raddr);
    end
  endtask

  // mode 0: always ready; mode 1: hold ready low 5 cycles on idx 7; mode 2: random ready
  task automatic test_dump_full(input int mode);
    int exp_idx[$];
    logic [31:0] exp_dat[$];
    int cyc, hold, acc_cyc, words, first_valid;
    bit seen_done, prev_held;
    for (int k = 0; k < 32; k++) begin
      exp_idx.push_back(k);
      exp_dat.push_back(rf[k]);
    end
    hold = 0; acc_cyc = -10; words = 0; first_valid = -1; seen_done = 1'b0; prev_held = 1'b0;
    if0.dout_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (cyc = 0; cyc < 600 && !seen_done; cyc++) begin
      if (prev_held) begin
        checks++;
        if (if0.dout_valid !== 1'b1) begin
          errors++;
          $display("FAIL held_valid mode=%0d cyc=%0d got %b want 1", mode, cyc, if0.dout_valid);
        end
      end
      prev_held = 1'b0;
      if (done0 === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (cyc != acc_cyc || exp_idx.size() != 0) begin
          errors++;
          $display("FAIL done_timing mode=%0d got cyc=%0d left=%0d want cyc=%0d left=0",
                   mode, cyc, exp_idx.size(), acc_cyc);
        end
        if (mode == 0) begin
          checks++;
          if (cyc != 65) begin
            errors++;
            $display("FAIL throughput got done at cyc %0d want 65", cyc);
          end
        end
      end else begin
        checks++;
        if (stall0 !== 1'b1 || busy0 !== 1'b1) begin
          errors++;
          $display("FAIL stall_busy mode=%0d cyc=%0d got %b/%b want 1/1", mode, cyc, stall0, busy0);
        end
        if (if0.dout_valid === 1'b1) begin
          if (first_valid < 0) begin
            first_valid = cyc;
            checks++;
            if (cyc != 2) begin
              errors++;
              $display("FAIL latency mode=%0d got first valid at %0d want 2", mode, cyc);
            end
          end
          checks++;
          if (exp_idx.size() == 0) begin
            errors++;
            $display("FAIL extra_word mode=%0d got idx=%0d want none", mode, if0.dout_idx);
            if0.dout_ready = 1'b1;
          end else begin
            if (if0.dout_idx !== 5'(exp_idx[0]) || if0.dout_data !== exp_dat[0] ||
                if0.dout_last !== (exp_idx[0] == 31)) begin
              errors++;
              $display("FAIL word mode=%0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                       mode, if0.dout_idx, if0.dout_data, if0.dout_last,
                       exp_idx[0], exp_dat[0], (exp_idx[0] == 31));
            end
            if (mode == 1 && exp_idx[0] == 7 && hold < 5) begin
              if0.dout_ready = 1'b0;
              hold++;
            end else begin
              if0.dout_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (if0.dout_ready) begin
              void'(exp_idx.pop_front());
              void'(exp_dat.pop_front());
              words++;
              acc_cyc = cyc + 1;
            end else begin
              prev_held = 1'b1;
            end
          end
        end else begin
          if0.dout_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        tick();
      end
    end
    checks++;
    if (!seen_done || words != 32) begin
      errors++;
      $display("FAIL completion mode=%0d got done=%b words=%0d want 1 and 32", mode, seen_done, words);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || stall0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL post_done mode=%0d got d=%b s=%b b=%b want 0/0/0", mode, done0, stall0, busy0);
    end
  endtask

  task automatic test_range();
    int widx[$];
    int cyc;
    bit seen_done;
    seen_done = 1'b0;
    if1.dout_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      checks++;
      if (stall1 !== 1'b1) begin
        errors++;
        $display("FAIL range_stall cyc=%0d got %b want 1", cyc, stall1);
      end
      if (done1 === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (if1.dout_valid === 1'b1) begin
          checks++;
          if (if1.dout_data !== rf[if1.dout_idx] || if1.dout_last !== (if1.dout_idx == 5'd3)) begin
            errors++;
            $display("FAIL range_word idx=%0d got data=%h last=%b want data=%h last=%b",
                     if1.dout_idx, if1.dout_data, if1.dout_last, rf[if1.dout_idx], (if1.dout_idx == 5'd3));
          end
          widx.push_back(int'(if1.dout_idx));
        end
        tick();
      end
    end
    checks++;
    if (!seen_done || widx.size() != 3) begin
      errors++;
      $display("FAIL range_count got done=%b words=%0d want 1 and 3", seen_done, widx.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (widx[k] != k + 1) begin
          errors++;
          $display("FAIL range_idx got %0d want %0d", widx[k], k + 1);
        end
      end
    end
    tick();
    checks++;
    if (stall1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL range_idle got s=%b b=%b d=%b want 0/0/0", stall1, busy1, done1);
    end
  endtask

  task automatic test_single_settle_write();
    int words;
    bit seen_done;
    words = 0; seen_done = 1'b0;
    rf[5] = 32'h5555_5555;
    if2.dout_ready = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    @(negedge clk);
    rf[5] = 32'hDEAD_BEEF;
    tick();
    for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
      if (done2 === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (if2.dout_valid === 1'b1) begin
          words++;
          checks++;
          if (if2.dout_data !== 32'hDEAD_BEEF || if2.dout_idx !== 5'd5 || if2.dout_last !== 1'b1) begin
            errors++;
            $display("FAIL settle_write got data=%h idx=%0d last=%b want deadbeef 5 1",
                     if2.dout_data, if2.dout_idx, if2.dout_last);
          end
        end
        tick();
      end
    end
    checks++;
    if (!seen_done || words != 1) begin
      errors++;
      $display("FAIL single_count got done=%b words=%0d want 1 and 1", seen_done, words);
    end
    tick();
  endtask

  task automatic test_abort();
    bit found, seen_done;
    found = 1'b0; seen_done = 1'b0;
    if0.dout_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (if0.dout_valid === 1'b1 && if0.dout_idx === 5'd12) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach got no idx 12 want idx 12 in SEND");
    end
    if0.dout_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (if0.dout_valid !== 1'b0 || stall0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        if0.dout_last !== 1'b0 || if0.dout_data !== 32'd0 || if0.dout_idx !== 5'd0 ||
        if0.rf_raddr !== 5'd0) begin
      errors++;
      $display("FAIL abort_reset got v=%b s=%b b=%b d=%b l=%b data=%h idx=%0d raddr=%0d want zeros",
               if0.dout_valid, stall0, busy0, done0, if0.dout_last, if0.dout_data,
               if0.dout_idx, if0.rf_raddr);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet got d=%b b=%b want 0/0", done0, busy0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    if0.dout_ready = 1'b1;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (if0.dout_valid === 1'b1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || if0.dout_idx !== 5'd0 || if0.dout_data !== rf[0]) begin
      errors++;
      $display("FAIL abort_restart got valid=%b idx=%0d data=%h want 1 0 %h",
               found, if0.dout_idx, if0.dout_data, rf[0]);
    end
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (done0 === 1'b1) seen_done = 1'b1;
      else tick();
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL abort_finish got no done want done");
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones, words;
    bit seen_done, busy_bad;
    dones = 0; words = 0; seen_done = 1'b0; busy_bad = 1'b0;
    if0.dout_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      start0 = (cyc == 10 || cyc == 31);
      if (if0.dout_valid === 1'b1) words++;
      if (done0 === 1'b1) begin
        dones++;
        seen_done = 1'b1;
        start0 = 1'b1;
      end
      tick();
    end
    start0 = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (done0 === 1'b1) dones++;
      if (busy0 !== 1'b0) busy_bad = 1'b1;
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_done got %0d done pulses want 1", dones);
    end
    checks++;
    if (words != 32) begin
      errors++;
      $display("FAIL ignore_words got %0d words want 32", words);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL ignore_busy got busy after DONE want 0");
    end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    if0.dout_ready = 1'b1; if1.dout_ready = 1'b1; if2.dout_ready = 1'b1;
    for (int k = 0; k < 32; k++) rf[k] = 32'h1111_1111 * 32'(k);
    #2;
    rst = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_dump_full(0);
    test_dump_full(1);
    test_range();
    test_single_settle_write();
    test_abort();
    test_start_ignored();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      test_dump_full(2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
